// File: rtl/vga_sync_receiver.sv
// Receive-side VGA timing recovery: rebuilds beam position from
// HSync/VSync, qualifies line/frame timing and flags lock.
module vga_sync_receiver #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FPORCH    = 16,
  parameter int H_PULSE     = 96,
  parameter int H_MAX       = 800,
  parameter int V_ACTIVE    = 480,
  parameter int V_FPORCH    = 10,
  parameter int V_MAX       = 525,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_LINES  = 4
) (
  input  logic       i_Clk,
  input  logic       i_Reset_n,
  input  logic       i_HSync,
  input  logic       i_VSync,
  input  logic [8:0] i_RGB,
  output logic [9:0] o_Column,
  output logic [9:0] o_Row,
  output logic       o_Active,
  output logic [8:0] o_RGB,
  output logic       o_Locked,
  output logic       o_Frame_Start,
  output logic       o_Line_Error
);

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    LOCKED
  } state_t;

  localparam logic [9:0]  H_LOAD = 10'(H_ACTIVE + H_FPORCH);
  localparam logic [9:0]  H_LAST = 10'(H_MAX - 1);
  localparam logic [9:0]  H_HALF = 10'(H_MAX / 2);
  localparam logic [9:0]  H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0]  V_LOAD = 10'(V_ACTIVE + V_FPORCH);
  localparam logic [9:0]  V_PRE  = 10'(V_ACTIVE + V_FPORCH - 1);
  localparam logic [9:0]  V_LAST = 10'(V_MAX - 1);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [10:0] LEN_OK = 11'(H_MAX - 1);
  localparam logic [10:0] LEN_TO = 11'(2 * H_MAX);
  localparam logic [10:0] PW_OK  = 11'(H_PULSE);
  localparam logic [7:0]  LOCK_N = 8'(LOCK_LINES);

  logic [SYNC_STAGES-1:0]      hs_pipe;
  logic [SYNC_STAGES-1:0]      vs_pipe;
  logic [SYNC_STAGES-1:0][8:0] rgb_pipe;
  logic                        hs_d;
  logic                        vs_d;

  logic [9:0]  col_q;
  logic [9:0]  row_q;
  logic        vs_pend;
  logic [10:0] len_q;
  logic [10:0] low_q;
  logic [10:0] pw_q;

  state_t      state;
  logic [7:0]  good_cnt;
  logic        vs_seen;

  logic        hs_s;
  logic        vs_s;
  logic [8:0]  rgb_s;
  logic        hs_fall;
  logic        hs_rise;
  logic        vs_fall;
  logic        line_end;
  logic        vs_early;
  logic [9:0]  col_now;
  logic [9:0]  row_step;
  logic [9:0]  row_now;
  logic [9:0]  row_exp;
  logic        frame_bad;
  logic        line_good;
  logic        bad_line;
  logic        timeout;
  logic        lk;
  logic        act;

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      hs_pipe  <= '1;
      vs_pipe  <= '1;
      rgb_pipe <= '0;
      hs_d     <= 1'b1;
      vs_d     <= 1'b1;
    end else begin
      hs_pipe  <= {hs_pipe[SYNC_STAGES-2:0], i_HSync};
      vs_pipe  <= {vs_pipe[SYNC_STAGES-2:0], i_VSync};
      rgb_pipe <= {rgb_pipe[SYNC_STAGES-2:0], i_RGB};
      hs_d     <= hs_s;
      vs_d     <= vs_s;
    end
  end

  always_comb begin
    hs_s     = hs_pipe[SYNC_STAGES-1];
    vs_s     = vs_pipe[SYNC_STAGES-1];
    rgb_s    = rgb_pipe[SYNC_STAGES-1];
    hs_fall  = hs_d & ~hs_s;
    hs_rise  = ~hs_d & hs_s;
    vs_fall  = vs_d & ~vs_s;
    line_end = ~hs_fall & (col_q == H_LAST);
    if (hs_fall)
      col_now = H_LOAD;
    else if (line_end)
      col_now = '0;
    else
      col_now = col_q + 10'd1;
    row_step = row_q;
    if (line_end)
      row_step = (row_q == V_LAST) ? '0 : row_q + 10'd1;
    // A VSync fall in the second half of a line belongs to the next one
    vs_early = vs_fall & (col_now < H_HALF);
    row_now  = row_step;
    if (vs_early | (line_end & vs_pend))
      row_now = V_LOAD;
    row_exp   = vs_early ? V_LOAD : V_PRE;
    frame_bad = vs_fall & (row_step != row_exp);
    line_good = (len_q == LEN_OK) & (pw_q == PW_OK);
    bad_line  = hs_fall & ~line_good;
    timeout   = ~hs_fall & (len_q == LEN_TO - 11'd1);
    lk        = (state == LOCKED);
    act       = lk & (col_now < H_ACT) & (row_now < V_ACT);
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      col_q   <= '0;
      row_q   <= '0;
      vs_pend <= 1'b0;
      len_q   <= '0;
      low_q   <= '0;
      pw_q    <= '0;
    end else begin
      col_q <= col_now;
      row_q <= row_now;
      if (vs_fall & ~vs_early)
        vs_pend <= 1'b1;
      else if (line_end)
        vs_pend <= 1'b0;
      if (hs_fall)
        len_q <= '0;
      else if (len_q != LEN_TO)
        len_q <= len_q + 11'd1;
      if (hs_s)
        low_q <= '0;
      else if (low_q != '1)
        low_q <= low_q + 11'd1;
      if (hs_rise)
        pw_q <= low_q;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state         <= SEARCH;
      good_cnt      <= '0;
      vs_seen       <= 1'b0;
      o_Line_Error  <= 1'b0;
      o_Locked      <= 1'b0;
      o_Active      <= 1'b0;
      o_Frame_Start <= 1'b0;
      o_Column      <= '0;
      o_Row         <= '0;
      o_RGB         <= '0;
    end else begin
      o_Line_Error <= 1'b0;
      if (timeout) begin
        state        <= SEARCH;
        o_Line_Error <= lk;
      end else begin
        unique case (state)
          SEARCH: begin
            if (hs_fall) begin
              state    <= TRACK;
              good_cnt <= '0;
              vs_seen  <= 1'b0;
            end
          end
          TRACK: begin
            if (vs_fall)
              vs_seen <= 1'b1;
            if (hs_fall) begin
              if (!line_good)
                good_cnt <= '0;
              else if (good_cnt != LOCK_N)
                good_cnt <= good_cnt + 8'd1;
            end
            if (good_cnt >= LOCK_N && vs_seen)
              state <= LOCKED;
          end
          LOCKED: begin
            if (bad_line | frame_bad) begin
              state        <= SEARCH;
              o_Line_Error <= 1'b1;
            end
          end
          default: state <= SEARCH;
        endcase
      end
      o_Locked      <= lk;
      o_Active      <= act;
      o_Frame_Start <= lk & (col_now == '0) & (row_now == '0);
      o_Column      <= col_now;
      o_Row         <= row_now;
      o_RGB         <= act ? rgb_s : '0;
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver: vector table, corner sequences and a
// randomized loop-back generator against a delayed-position model.
module tb_vga_sync_receiver;

  localparam int HA = 64;
  localparam int HF = 8;
  localparam int HP = 12;
  localparam int HM = 100;
  localparam int VA = 40;
  localparam int VF = 5;
  localparam int VM = 50;
  localparam int VP = 2;
  localparam int HS0 = HA + HF;
  localparam int VS0 = VA + VF;
  localparam int FRAME = HM * VM;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hs = 1'b1;
  logic       vs = 1'b1;
  logic [8:0] rgb = '0;
  logic [9:0] o_Column;
  logic [9:0] o_Row;
  logic       o_Active;
  logic [8:0] o_RGB;
  logic       o_Locked;
  logic       o_Frame_Start;
  logic       o_Line_Error;

  always #5 clk = ~clk;

  vga_sync_receiver #(
    .H_ACTIVE(HA), .H_FPORCH(HF), .H_PULSE(HP), .H_MAX(HM),
    .V_ACTIVE(VA), .V_FPORCH(VF), .V_MAX(VM),
    .SYNC_STAGES(2), .LOCK_LINES(4)
  ) dut (
    .i_Clk(clk),
    .i_Reset_n(rst_n),
    .i_HSync(hs),
    .i_VSync(vs),
    .i_RGB(rgb),
    .o_Column(o_Column),
    .o_Row(o_Row),
    .o_Active(o_Active),
    .o_RGB(o_RGB),
    .o_Locked(o_Locked),
    .o_Frame_Start(o_Frame_Start),
    .o_Line_Error(o_Line_Error)
  );

  typedef struct {
    int         col;
    int         row;
    logic [8:0] rgb;
  } pos_t;

  typedef struct {
    logic       hs;
    logic       vs;
    logic [9:0] col;
    logic [9:0] row;
  } vec_t;

  int   n_pass = 0;
  int   n_chk = 0;
  int   cyc = 0;
  int   err_seen = 0;
  int   g_col = 0;
  int   g_row = 0;
  int   late_row = -1;
  bit   hs_kill = 1'b0;
  bit   exp_ok = 1'b0;
  pos_t ex;
  pos_t hist[$];

  task automatic chk(input string name, input logic [39:0] act,
                     input logic [39:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [32:0] outs();
    return {o_Column, o_Row, o_RGB, o_Active, o_Locked,
            o_Frame_Start, o_Line_Error};
  endfunction

  task automatic tick(input logic h, input logic v);
    hs  = h;
    vs  = v;
    rgb = 9'($urandom);
    @(posedge clk);
    #1;
  endtask

  // Generator drives one pixel; the model output is the pixel from 3 clocks ago
  task automatic step();
    pos_t p;
    int   hs_start;
    hs_start = HS0 + ((g_row == late_row) ? 5 : 0);
    hs  = hs_kill ? 1'b1 : !(g_col >= hs_start && g_col < HS0 + HP);
    vs  = !(g_row >= VS0 && g_row < VS0 + VP);
    rgb = 9'($urandom);
    p.col = g_col;
    p.row = g_row;
    p.rgb = rgb;
    hist.push_back(p);
    @(posedge clk);
    #1;
    cyc++;
    exp_ok = (hist.size() == 3);
    if (exp_ok) ex = hist.pop_front();
    err_seen += int'(o_Line_Error);
    if (g_row == late_row && g_col == HM - 1) late_row = -1;
    g_col++;
    if (g_col == HM) begin
      g_col = 0;
      g_row = (g_row == VM - 1) ? 0 : g_row + 1;
    end
  endtask

  task automatic chk_track(input string name);
    logic a;
    logic fs;
    if (exp_ok) begin
      a  = (ex.col < HA) && (ex.row < VA);
      fs = (ex.col == 0) && (ex.row == 0);
      chk(name, 40'(outs()),
          40'({10'(ex.col), 10'(ex.row), a ? ex.rgb : 9'd0,
               a, 1'b1, fs, 1'b0}));
    end
  endtask

  task automatic wait_lock(input string name, input int budget);
    int n;
    n = 0;
    while (!o_Locked && n < budget) begin
      step();
      n++;
    end
    chk(name, 40'(o_Locked), 40'd1);
  endtask

  initial begin
    vec_t tbl[12];
    int   n;
    int   t0;
    int   fs_last;
    int   fs_cnt;
    int   act_cnt;
    int   hi_cnt;

    tbl[0]  = '{1'b1, 1'b1, 10'd1,  10'd0};
    tbl[1]  = '{1'b1, 1'b1, 10'd2,  10'd0};
    tbl[2]  = '{1'b1, 1'b0, 10'd3,  10'd0};
    tbl[3]  = '{1'b1, 1'b0, 10'd4,  10'd0};
    tbl[4]  = '{1'b0, 1'b0, 10'd5,  10'd45};
    tbl[5]  = '{1'b0, 1'b0, 10'd6,  10'd45};
    tbl[6]  = '{1'b0, 1'b0, 10'd72, 10'd45};
    tbl[7]  = '{1'b0, 1'b0, 10'd73, 10'd45};
    tbl[8]  = '{1'b0, 1'b0, 10'd74, 10'd45};
    tbl[9]  = '{1'b0, 1'b0, 10'd75, 10'd45};
    tbl[10] = '{1'b0, 1'b0, 10'd76, 10'd45};
    tbl[11] = '{1'b0, 1'b0, 10'd77, 10'd45};

    rgb = 9'h1FF;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 40'(outs()), 40'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].hs, tbl[i].vs);
      chk($sformatf("vec%0d", i), 40'(outs()),
          40'({tbl[i].col, tbl[i].row, 13'd0}));
    end

    // HSync and VSync fall together late in the line: row loads at wrap
    rst_n = 1'b0;
    tick(1'b1, 1'b1);
    rst_n = 1'b1;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("simul_fall", 40'({o_Column, o_Row}), 40'({10'd72, 10'd0}));
    n = 0;
    while (o_Column != 10'(HM - 1) && n < 60) begin
      tick(1'b0, 1'b0);
      n++;
    end
    chk("row_hold_late_vs", 40'({o_Column, o_Row}),
        40'({10'(HM - 1), 10'd0}));
    tick(1'b0, 1'b0);
    chk("row_load_at_wrap", 40'({o_Column, o_Row}),
        40'({10'd0, 10'(VS0)}));

    // Loop-back from a randomly phased generator
    rst_n = 1'b0;
    tick(1'b1, 1'b1);
    rst_n = 1'b1;
    hist.delete();
    g_col = int'($urandom_range(HM - 1));
    g_row = int'($urandom_range(VA / 2 - 1));
    err_seen = 0;
    wait_lock("lock_frame1", FRAME);
    chk("no_err_acquire", 40'(err_seen), 40'd0);
    n = 0;
    while (!(exp_ok && ex.col == 0 && ex.row == 0) && n < FRAME) begin
      step();
      chk_track("track_align");
      n++;
    end
    fs_last = cyc;
    fs_cnt  = 0;
    act_cnt = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      chk_track("track");
      act_cnt += int'(o_Active);
      if (o_Frame_Start) begin
        fs_cnt++;
        chk("fs_interval", 40'(cyc - fs_last), 40'(FRAME));
        fs_last = cyc;
      end
    end
    chk("fs_count", 40'(fs_cnt), 40'd2);
    chk("active_count", 40'(act_cnt), 40'(2 * HA * VA));
    chk("no_err_track", 40'(err_seen), 40'd0);

    // One HSync fall delayed by 5 clocks
    late_row = 10;
    n = 0;
    while (!o_Line_Error && n < FRAME) begin
      step();
      n++;
    end
    chk("late_hs_err", 40'(o_Line_Error), 40'd1);
    chk("late_hs_pos", 40'({10'(ex.col), 10'(ex.row)}),
        40'({10'(HS0 + 5), 10'd10}));
    step();
    chk("late_hs_unlock", 40'({o_Locked, o_Line_Error}), 40'd0);
    err_seen = 0;
    hi_cnt = 0;
    n = 0;
    while (!(g_row == VS0 && g_col == 0) && n < FRAME) begin
      step();
      hi_cnt += int'(o_Locked);
      n++;
    end
    chk("no_relock_before_vs", 40'(hi_cnt), 40'd0);
    wait_lock("relock_after_vs", 8 * HM);
    chk("no_err_relock", 40'(err_seen), 40'd0);
    for (int k = 0; k < 2 * HM; k++) begin
      step();
      chk_track("track_relock");
    end

    // HSync held high while locked
    n = 0;
    while (!(o_Column == 10'(HS0) && o_Locked) && n < 2 * HM) begin
      step();
      n++;
    end
    chk("last_fall_seen", 40'(o_Column), 40'(HS0));
    t0 = cyc;
    hs_kill = 1'b1;
    err_seen = 0;
    n = 0;
    while (!o_Line_Error && n < 4 * HM) begin
      step();
      n++;
    end
    chk("timeout_delay", 40'(cyc - t0), 40'(2 * HM));
    step();
    chk("timeout_unlock", 40'(o_Locked), 40'd0);
    act_cnt = 0;
    for (int k = 0; k < 3 * HM; k++) begin
      step();
      act_cnt += int'(o_Active);
    end
    chk("timeout_inactive", 40'(act_cnt), 40'd0);
    chk("timeout_single_err", 40'(err_seen), 40'd1);
    hs_kill = 1'b0;

    // Asynchronous reset mid-line at row 20
    wait_lock("relock_after_timeout", 2 * FRAME);
    n = 0;
    while (!(g_row == 20 && g_col == 30) && n < FRAME + 1) begin
      step();
      n++;
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 40'(outs()), 40'd0);
    repeat (3) step();
    chk("reset_hold", 40'(outs()), 40'd0);
    rst_n = 1'b1;
    err_seen = 0;
    wait_lock("relock_after_reset", 2 * FRAME);
    for (int k = 0; k < 2 * HM; k++) begin
      step();
      chk_track("track_after_reset");
    end
    chk("no_err_after_reset", 40'(err_seen), 40'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
